// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_if
// Brief   : Result-source, scoreboard-query and register-file write bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_writeback_if #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4
);
    localparam int c_lvl_w = $clog2(FIFO_DEPTH) + 1;

    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]     alu_data;
    logic                      ld_valid;
    logic                      ld_ready;
    logic [REG_ADDR_WIDTH-1:0] ld_rd;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      pend_set;
    logic [REG_ADDR_WIDTH-1:0] pend_rd;
    logic [REG_ADDR_WIDTH-1:0] q_reg1;
    logic [REG_ADDR_WIDTH-1:0] q_reg2;
    logic                      q_busy1;
    logic                      q_busy2;
    logic                      write_en;
    logic [REG_ADDR_WIDTH-1:0] regw;
    logic [DATA_WIDTH-1:0]     dataw;
    logic [c_lvl_w-1:0]        fifo_level;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output pend_set, pend_rd, q_reg1, q_reg2,
        input  ld_ready, q_busy1, q_busy2,
        input  write_en, regw, dataw, fifo_level
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  pend_set, pend_rd, q_reg1, q_reg2,
        output ld_ready, q_busy1, q_busy2,
        output write_en, regw, dataw, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_unit
// Brief   : Register-file write-port arbiter (ALU priority, buffered loads)
//           with a pending-load scoreboard for decode hazard checks.
// Revision: 1.0 - initial release
// ============================================================================
module reg_writeback_unit #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    reg_writeback_if.slave    bus
);
    localparam int c_num_regs = 2 ** REG_ADDR_WIDTH;
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w    = c_ptr_w + 1;
    localparam int c_entry_w  = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(FIFO_DEPTH);

    logic [c_entry_w-1:0]      r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [c_lvl_w-1:0]        r_count;
    logic                      r_write_en;
    logic                      r_from_load;
    logic [REG_ADDR_WIDTH-1:0] r_regw;
    logic [DATA_WIDTH-1:0]     r_dataw;
    logic [c_num_regs-1:0]     r_pend;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_ready;
    logic                      w_push;
    logic                      w_pop;
    logic [REG_ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0]     w_head_data;
    logic [c_num_regs-1:0]     w_pend_next;

    assign w_full  = (r_count == c_full_lvl);
    assign w_empty = (r_count == '0);
    // Ready is masked by reset so no load is accepted while the unit is held.
    assign w_ready = rst_n && !w_full;
    assign w_push  = bus.ld_valid && w_ready;
    assign w_pop   = !bus.alu_valid && !w_empty;

    assign {w_head_rd, w_head_data} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.ld_rd, bus.ld_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Results to r0 still update regw/dataw but never raise write_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write_en  <= 1'b0;
            r_from_load <= 1'b0;
            r_regw      <= '0;
            r_dataw     <= '0;
        end else if (bus.alu_valid) begin
            r_write_en  <= (bus.alu_rd != '0);
            r_from_load <= 1'b0;
            r_regw      <= bus.alu_rd;
            r_dataw     <= bus.alu_data;
        end else if (w_pop) begin
            r_write_en  <= (w_head_rd != '0);
            r_from_load <= (w_head_rd != '0);
            r_regw      <= w_head_rd;
            r_dataw     <= w_head_data;
        end else begin
            r_write_en  <= 1'b0;
            r_from_load <= 1'b0;
        end
    end

    // Clear on the commit edge of a load write, then apply set so set wins.
    always_comb begin
        w_pend_next = r_pend;
        if (r_write_en && r_from_load) begin
            w_pend_next[r_regw] = 1'b0;
        end
        if (bus.pend_set && (bus.pend_rd != '0)) begin
            w_pend_next[bus.pend_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign bus.ld_ready   = w_ready;
    assign bus.q_busy1    = r_pend[bus.q_reg1];
    assign bus.q_busy2    = r_pend[bus.q_reg2];
    assign bus.write_en   = r_write_en;
    assign bus.regw       = r_regw;
    assign bus.dataw      = r_dataw;
    assign bus.fifo_level = r_count;
endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_writeback_unit
// Brief   : Directed self-checking bench for reg_writeback_unit.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_writeback_unit;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int DATA_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    reg_writeback_if #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) bus ();

    reg_writeback_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        bus.pend_set  = 1'b0;
        bus.pend_rd   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        bus.q_reg1 = '0;
        bus.q_reg2 = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        chk("rst_regw", 32'(bus.regw), 32'd0);
        chk("rst_dataw", 32'(bus.dataw), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ld_ready", 32'(bus.ld_ready), 32'd1);

        // ALU write: one-cycle latency, single pulse, address held afterwards
        tick();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd3;
        bus.alu_data  = 8'h5A;
        tick();
        bus.alu_valid = 1'b0;
        chk("alu_we", 32'(bus.write_en), 32'd1);
        chk("alu_regw", 32'(bus.regw), 32'd3);
        chk("alu_dataw", 32'(bus.dataw), 32'h5A);
        chk("alu_ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        chk("alu_we_drop", 32'(bus.write_en), 32'd0);
        chk("alu_regw_hold", 32'(bus.regw), 32'd3);

        // Scoreboard set, load commit, clear
        bus.pend_set = 1'b1;
        bus.pend_rd  = 4'd5;
        bus.q_reg1   = 4'd5;
        #1;
        chk("pend_not_yet", 32'(bus.q_busy1), 32'd0);
        tick();
        bus.pend_set = 1'b0;
        #1;
        chk("pend_busy_c1", 32'(bus.q_busy1), 32'd1);
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 4'd5;
        bus.ld_data  = 8'h11;
        tick();
        bus.ld_valid = 1'b0;
        chk("ld_lat_c3_we", 32'(bus.write_en), 32'd0);
        chk("ld_lat_c3_level", 32'(bus.fifo_level), 32'd1);
        chk("pend_busy_c3", 32'(bus.q_busy1), 32'd1);
        tick();
        chk("ld_c4_we", 32'(bus.write_en), 32'd1);
        chk("ld_c4_regw", 32'(bus.regw), 32'd5);
        chk("ld_c4_dataw", 32'(bus.dataw), 32'h11);
        chk("pend_busy_c4", 32'(bus.q_busy1), 32'd1);
        tick();
        chk("pend_clear_c5", 32'(bus.q_busy1), 32'd0);
        chk("ld_c5_we", 32'(bus.write_en), 32'd0);

        // Fill FIFO under continuous ALU traffic
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd7;
        bus.alu_data  = 8'h77;
        for (int i = 1; i <= 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 4'(i);
            bus.ld_data  = 8'(8'hA0 + i);
            #1;
            chk("fill_ready", 32'(bus.ld_ready), 32'd1);
            tick();
        end
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        #1;
        chk("full_ready", 32'(bus.ld_ready), 32'd0);
        chk("full_level", 32'(bus.fifo_level), 32'd4);
        chk("full_alu_we", 32'(bus.write_en), 32'd1);
        chk("full_alu_regw", 32'(bus.regw), 32'd7);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain_we", 32'(bus.write_en), 32'd1);
            chk("drain_regw", 32'(bus.regw), 32'(i));
            chk("drain_dataw", 32'(bus.dataw), 32'(8'hA0 + i));
            chk("drain_level", 32'(bus.fifo_level), 32'(4 - i));
            chk("drain_ready", 32'(bus.ld_ready), 32'd1);
        end
        tick();
        chk("drain_idle_we", 32'(bus.write_en), 32'd0);

        // r0 load: consumed silently; r0 pending never sets
        bus.pend_set = 1'b1;
        bus.pend_rd  = 4'd0;
        bus.q_reg1   = 4'd0;
        bus.q_reg2   = 4'd0;
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 4'd0;
        bus.ld_data  = 8'hFF;
        tick();
        bus.pend_set = 1'b0;
        bus.ld_rd    = 4'd2;
        bus.ld_data  = 8'h22;
        #1;
        chk("r0_busy1", 32'(bus.q_busy1), 32'd0);
        tick();
        bus.ld_valid = 1'b0;
        chk("r0_pop_we", 32'(bus.write_en), 32'd0);
        chk("r0_pop_level", 32'(bus.fifo_level), 32'd1);
        chk("r0_busy2", 32'(bus.q_busy2), 32'd0);
        tick();
        chk("r2_we", 32'(bus.write_en), 32'd1);
        chk("r2_regw", 32'(bus.regw), 32'd2);
        chk("r2_dataw", 32'(bus.dataw), 32'h22);
        tick();

        // Mid-cycle reset with FIFO holding 3 entries and a pending bit set
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd6;
        bus.alu_data  = 8'h66;
        bus.pend_set  = 1'b1;
        bus.pend_rd   = 4'd9;
        bus.q_reg1    = 4'd9;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 4'(10 + i);
            bus.ld_data  = 8'(8'hC0 + i);
            tick();
            bus.pend_set = 1'b0;
        end
        bus.ld_valid = 1'b0;
        #1;
        chk("prerst_level", 32'(bus.fifo_level), 32'd3);
        chk("prerst_busy", 32'(bus.q_busy1), 32'd1);
        chk("prerst_we", 32'(bus.write_en), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(bus.write_en), 32'd0);
        chk("midrst_level", 32'(bus.fifo_level), 32'd0);
        chk("midrst_busy", 32'(bus.q_busy1), 32'd0);
        chk("midrst_ready", 32'(bus.ld_ready), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_we", 32'(bus.write_en), 32'd0);
            chk("postrst_level", 32'(bus.fifo_level), 32'd0);
        end

        // Streaming loads across pointer wrap, rd cycling 0..15
        for (int i = 0; i < 20; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = 4'(i % 16);
            bus.ld_data  = 8'(8'h30 + i);
            tick();
            chk("stream_level", 32'(bus.fifo_level), 32'd1);
            if (i > 0) begin
                chk("stream_we", 32'(bus.write_en), ((i - 1) % 16 == 0) ? 32'd0 : 32'd1);
                chk("stream_regw", 32'(bus.regw), 32'((i - 1) % 16));
                chk("stream_dataw", 32'(bus.dataw), 32'(8'(8'h30 + i - 1)));
            end
        end
        bus.ld_valid = 1'b0;
        tick();
        chk("stream_last_we", 32'(bus.write_en), 32'd1);
        chk("stream_last_regw", 32'(bus.regw), 32'd3);
        chk("stream_last_dataw", 32'(bus.dataw), 32'h43);
        tick();
        chk("stream_end_we", 32'(bus.write_en), 32'd0);
        chk("stream_end_level", 32'(bus.fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
